// File: rtl/dcfifo_pkg.sv
// dcfifo_pkg: shared state encoding and width helper for the dcfifo write-side blocks
package dcfifo_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
  function automatic int clog2(input int v);
    for (int r = 0; r < 31; r++)
      if ((1 << r) >= v) return r;
    return 31;
  endfunction
endpackage

// File: rtl/dcfifo_rr_pick.sv
// dcfifo_rr_pick: first requester at or after ptr, searching modulo NUM_SRC
module dcfifo_rr_pick
  import dcfifo_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);
  logic [ID_W-1:0] c;
  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = '0;
    // scan farthest-first so the nearest hit is the last assignment
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      c = ID_W'((int'(ptr) + k) % NUM_SRC);
      if (req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/dcfifo_wr_arbiter.sv
// dcfifo_wr_arbiter: round-robin burst arbiter sharing the dcfifo write port
module dcfifo_wr_arbiter
  import dcfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int BURST_MAX  = 4,
  localparam int ID_W      = clog2(NUM_SRC)
) (
  input  logic                          wr_clk,
  input  logic                          wr_reset,
  input  logic                          arb_en,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          fifo_wr_full,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_req,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id,
  output logic [15:0]                   words_written
);
  localparam int BW = clog2(BURST_MAX) + 1;
  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr, owner, pick_idx;
  logic [BW-1:0]   beat_cnt;
  logic            pick_any, in_burst, fire, burst_end;
  dcfifo_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req(src_valid),
    .ptr(rr_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );
  // a word presented while reset is asserted must never reach the FIFO
  always_comb begin
    in_burst     = state_q == ST_BURST;
    fire         = in_burst & src_valid[owner] & ~fifo_wr_full & ~wr_reset;
    burst_end    = in_burst & ((fire & (beat_cnt == BW'(BURST_MAX - 1))) | ~src_valid[owner]);
    state_d      = in_burst ? (burst_end ? ST_IDLE : ST_BURST)
                            : ((arb_en & pick_any) ? ST_BURST : ST_IDLE);
    grant_valid  = in_burst;
    grant_id     = in_burst ? owner : '0;
    fifo_wr_req  = fire;
    src_ready    = fire ? NUM_SRC'(1) << owner : '0;
    fifo_data_in = in_burst ? src_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      state_q       <= ST_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      beat_cnt      <= '0;
      words_written <= '0;
    end else begin
      state_q <= state_d;
      if (!in_burst && arb_en && pick_any) begin
        owner    <= pick_idx;
        beat_cnt <= '0;
      end
      if (fire) begin
        beat_cnt      <= beat_cnt + 1'b1;
        words_written <= words_written + 16'd1;
      end
      if (burst_end) rr_ptr <= (owner == ID_W'(NUM_SRC - 1)) ? '0 : owner + 1'b1;
    end
  end
endmodule

// File: tb/tb_dcfifo_wr_arbiter.sv
// tb_dcfifo_wr_arbiter: directed checks of arbitration, stalls, release, arb_en and wrap
module tb_dcfifo_wr_arbiter;
  localparam int DW = 32;
  localparam int NS = 4;
  logic              wr_clk = 1'b0;
  logic              wr_reset = 1'b1;
  logic              arb_en = 1'b0;
  logic              fifo_wr_full = 1'b0;
  logic              clr = 1'b1;
  logic [NS-1:0]     en = '0;
  logic [NS-1:0]     src_valid, src_ready;
  logic [NS*DW-1:0]  src_data;
  logic [DW-1:0]     fifo_data_in;
  logic              fifo_wr_req, grant_valid;
  logic [1:0]        grant_id;
  logic [15:0]       words_written;
  int                sent[NS];
  int                lim[NS];
  int                cyc = 0;
  int                ovf = 0;
  int                checks = 0;
  int                fails = 0;
  logic [DW-1:0]     wlog[$];
  int                wcyc[$];

  always #5 wr_clk = ~wr_clk;

  dcfifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .BURST_MAX(4)) dut (
    .wr_clk(wr_clk),
    .wr_reset(wr_reset),
    .arb_en(arb_en),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .fifo_wr_full(fifo_wr_full),
    .fifo_data_in(fifo_data_in),
    .fifo_wr_req(fifo_wr_req),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .words_written(words_written)
  );

  // source i emits 0xA0+16*i+n for its n-th word, valid until lim[i] words are accepted
  always_comb begin
    src_valid = '0;
    src_data  = '0;
    for (int i = 0; i < NS; i++) begin
      src_valid[i]         = en[i] && (sent[i] < lim[i]);
      src_data[i*DW +: DW] = DW'(32'hA0 + 16 * i + sent[i]);
    end
  end

  // FIFO-side model: log every write and flag any write into a full FIFO
  always @(posedge wr_clk) begin
    cyc = cyc + 1;
    if (clr) begin
      wlog.delete();
      wcyc.delete();
    end else if (fifo_wr_req) begin
      wlog.push_back(fifo_data_in);
      wcyc.push_back(cyc);
      if (fifo_wr_full) ovf = ovf + 1;
    end
    for (int i = 0; i < NS; i++)
      sent[i] <= clr ? 0 : (src_ready[i] ? sent[i] + 1 : sent[i]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_reset = 1'b1;
    clr = 1'b1;
    arb_en = 1'b0;
    fifo_wr_full = 1'b0;
    en = '0;
    repeat (2) tick();
    wr_reset = 1'b0;
    clr = 1'b0;
  endtask

  task automatic wait_words(input int n, input int bound);
    int k;
    k = 0;
    while (wlog.size() < n && k < bound) begin
      tick();
      k++;
    end
    if (wlog.size() < n) chk("timeout_words", wlog.size(), n);
  endtask

  initial begin
    int errs;
    int k;
    // reset with every source requesting
    lim = '{1000, 1000, 1000, 1000};
    en = 4'hF;
    arb_en = 1'b1;
    wr_reset = 1'b1;
    clr = 1'b1;
    repeat (2) tick();
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_wr_req", fifo_wr_req, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_words", words_written, 0);

    // round-robin between src0 and src2
    do_reset();
    lim = '{8, 0, 4, 0};
    en = 4'b0101;
    arb_en = 1'b1;
    wait_words(12, 100);
    repeat (3) tick();
    chk("rr_count", wlog.size(), 12);
    for (int i = 0; i < 4 && i + 8 < wlog.size(); i++) begin
      chk("rr_a_first", wlog[i], 32'hA0 + i);
      chk("rr_c", wlog[i+4], 32'hC0 + i);
      chk("rr_a_second", wlog[i+8], 32'hA4 + i);
    end
    if (wcyc.size() >= 9) begin
      chk("rr_gap1", wcyc[4] - wcyc[3], 2);
      chk("rr_gap2", wcyc[8] - wcyc[7], 2);
    end
    chk("rr_words", words_written, 12);

    // full stall after beat 2
    do_reset();
    lim = '{4, 0, 0, 0};
    en = 4'b0001;
    arb_en = 1'b1;
    wait_words(2, 20);
    fifo_wr_full = 1'b1;
    repeat (5) begin
      #1;
      chk("stall_wr_req", fifo_wr_req, 0);
      chk("stall_ready", src_ready, 0);
      chk("stall_grant", grant_valid, 1);
      chk("stall_id", grant_id, 0);
      tick();
    end
    fifo_wr_full = 1'b0;
    wait_words(4, 20);
    repeat (3) tick();
    chk("stall_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("stall_data", wlog[i], 32'hA0 + i);
    chk("stall_words", words_written, 4);
    chk("stall_ovf", ovf, 0);

    // src1 releases early, src2 gets the next grant even though src1 comes back
    do_reset();
    lim = '{0, 2, 4, 0};
    en = 4'b0110;
    arb_en = 1'b1;
    wait_words(2, 20);
    tick();
    chk("early_idle", grant_valid, 0);
    lim[1] = 4;
    tick();
    chk("early_grant", grant_valid, 1);
    chk("early_id", grant_id, 2);
    wait_words(6, 30);
    if (wlog.size() >= 6) begin
      chk("early_b0", wlog[0], 32'hB0);
      chk("early_b1", wlog[1], 32'hB1);
      for (int i = 0; i < 4; i++) chk("early_c", wlog[i+2], 32'hC0 + i);
    end

    // arb_en drops mid-burst of src3
    do_reset();
    lim = '{100, 100, 100, 100};
    en = 4'b1000;
    arb_en = 1'b1;
    wait_words(2, 20);
    arb_en = 1'b0;
    repeat (10) tick();
    chk("hold_count", wlog.size(), 4);
    chk("hold_grant", grant_valid, 0);
    chk("hold_words", words_written, 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("hold_data", wlog[i], 32'hD0 + i);
    en = 4'b1010;
    arb_en = 1'b1;
    tick();
    chk("resume_grant", grant_valid, 1);
    chk("resume_id", grant_id, 1);

    // 65537 writes from one source with sporadic full
    do_reset();
    lim = '{65537, 0, 0, 0};
    en = 4'b0001;
    arb_en = 1'b1;
    k = 0;
    while (wlog.size() < 65537 && k < 90000) begin
      fifo_wr_full = (k % 64) == 0;
      tick();
      k++;
    end
    fifo_wr_full = 1'b0;
    repeat (3) tick();
    chk("wrap_count", wlog.size(), 65537);
    chk("wrap_words", words_written, 1);
    errs = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] !== 32'(32'hA0 + i)) errs++;
    chk("wrap_order_errors", errs, 0);
    chk("wrap_ovf", ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
